// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and the request legality check applied at capture time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    // High when the request is misaligned or its funct3 is not a legal load/store size.
    function automatic logic req_is_bad(input logic store, input logic [2:0] funct3,
                                        input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = offset[0];
            F3_W:    bad = (offset != 2'b00);
            F3_BU:   bad = store;
            F3_HU:   bad = store | offset[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering between a 32-bit memory word and sub-word data:
// store merge into an old word and load extract with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] load_word,
    input  logic [2:0]  funct3,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = load_word[{offset, 3'b000} +: 8];
    assign half_s = load_word[{offset[1], 4'b0000} +: 16];

    // Store merge: overwrite only the addressed lanes of the old word.
    always_comb begin
        merged_word = old_word;
        case (size)
            2'b00:   merged_word[{offset, 3'b000} +: 8] = wdata[7:0];
            2'b01:   merged_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            2'b10:   merged_word = wdata;
            default: merged_word = old_word;
        endcase
    end

    // Load extract: select the addressed lane and extend it to 32 bits.
    always_comb begin
        load_data = 32'h0000_0000;
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_W:    load_data = load_word;
            F3_BU:   load_data = {24'h00_0000, byte_s};
            F3_HU:   load_data = {16'h0000, half_s};
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte/half/word requests into word-aligned Memory
// accesses, using read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_rw,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] LAT_M1 = 3'(MEM_RD_LAT - 1);

    lsu_state_e        state_r;
    lsu_state_e        next_state_s;

    logic              store_r;
    logic [2:0]        funct3_r;
    logic [1:0]        offset_r;
    logic [31:0]       wdata_r;
    logic              err_r;
    logic [2:0]        wait_cnt_r;

    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_err_r;
    logic              mem_rw_r;
    logic              mem_wr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;

    logic              accept_s;
    logic              cap_bad_s;
    logic              wait_done_s;
    logic [31:0]       merged_s;
    logic [31:0]       load_data_s;

    assign accept_s    = req_valid && (state_r == ST_IDLE);
    assign cap_bad_s   = req_is_bad(req_store, req_funct3, req_addr[1:0]);
    assign wait_done_s = (state_r == ST_WAIT) && (wait_cnt_r == LAT_M1);

    lsu_align u_align (
        .old_word    (mem_rdata),
        .wdata       (wdata_r),
        .offset      (offset_r),
        .size        (funct3_r[1:0]),
        .load_word   (mem_rdata),
        .funct3      (funct3_r),
        .merged_word (merged_s),
        .load_data   (load_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; SW skips the read, errors skip memory entirely.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    next_state_s = ST_IDLE;
                end else if (cap_bad_s) begin
                    next_state_s = ST_RESP;
                end else if (req_store && (req_funct3 == F3_W)) begin
                    next_state_s = ST_WR;
                end else begin
                    next_state_s = ST_RD;
                end
            end
            ST_RD:   next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (!wait_done_s) begin
                    next_state_s = ST_WAIT;
                end else if (store_r) begin
                    next_state_s = ST_WR;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            ST_WR:   next_state_s = ST_RESP;
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Request capture and read-latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_r    <= 1'b0;
            funct3_r   <= 3'b000;
            offset_r   <= 2'b00;
            wdata_r    <= 32'h0000_0000;
            err_r      <= 1'b0;
            wait_cnt_r <= 3'd0;
        end else begin
            if (accept_s) begin
                store_r  <= req_store;
                funct3_r <= req_funct3;
                offset_r <= req_addr[1:0];
                wdata_r  <= req_wdata;
                err_r    <= cap_bad_s;
            end
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 3'd1;
            end else begin
                wait_cnt_r <= 3'd0;
            end
        end
    end

    // Registered outputs, each decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            mem_rw_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            req_ready_r <= (next_state_s == ST_IDLE);
            rsp_valid_r <= (next_state_s == ST_RESP);
            mem_rw_r    <= (next_state_s == ST_RD);
            mem_wr_r    <= (next_state_s == ST_WR);
            rsp_err_r   <= (next_state_s == ST_RESP) && (accept_s ? cap_bad_s : err_r);

            if (wait_done_s && !store_r) begin
                rsp_rdata_r <= load_data_s;
            end else begin
                rsp_rdata_r <= 32'h0000_0000;
            end

            if (accept_s) begin
                mem_addr_r <= {req_addr[ADDR_W-1:2], 2'b00};
            end

            if (accept_s && !cap_bad_s && req_store && (req_funct3 == F3_W)) begin
                mem_wdata_r <= req_wdata;
            end else if (wait_done_s && store_r) begin
                mem_wdata_r <= merged_s;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign mem_rw    = mem_rw_r;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// traffic compared against an arithmetic model of memory and the access rules.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_rw;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    int rw_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;
    logic [31:0] last_rd_addr;
    logic [31:0] mem_arr [16];
    logic [31:0] ref_mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_val = 32'h0;

    logic [31:0] g_rdata, e_rdata, e_wdata;
    logic        g_err, e_err, g_rdy, g_pulse;
    int          g_lat, g_rw, g_wr, e_lat, e_rw, e_wr;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_RD_LAT(1), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_rw     (mem_rw),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory model: one-cycle read latency, garbage on the read bus when not reading.
    always @(posedge clk) begin
        if (pl_en) mem_arr[pl_idx] <= pl_val;
        if (mem_wr) begin
            mem_arr[mem_addr[5:2]] <= mem_wdata;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
        end
        if (mem_rw) begin
            rw_cnt       <= rw_cnt + 1;
            last_rd_addr <= mem_addr;
        end
        if (mem_rw && mem_wr) both_cnt <= both_cnt + 1;
        mem_rdata <= mem_rw ? mem_arr[mem_addr[5:2]] : $urandom();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_word(input logic [3:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Reference: expected response, latency and memory traffic from the access rules.
    task automatic ref_model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] x_rdata,
                             output logic x_err, output int x_lat, output int x_rw,
                             output int x_wr, output logic [31:0] x_wdata);
        logic [31:0] w, b, h;
        int sh8, sh16;
        sh8  = int'(a[1:0]) * 8;
        sh16 = int'(a[1]) * 16;
        x_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3 >= 3'd4) ||
                ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
        x_rdata = 32'h0; x_rw = 0; x_wr = 0; x_wdata = 32'h0; x_lat = 1;
        if (!x_err) begin
            w = ref_mem[a[5:2]];
            b = (w >> sh8) & 32'hFF;
            h = (w >> sh16) & 32'hFFFF;
            if (st) begin
                x_wr = 1;
                if (f3 == 3'd2) begin
                    x_wdata = wd; x_lat = 2;
                end else if (f3 == 3'd0) begin
                    x_wdata = (w & ~(32'hFF << sh8)) | ((wd & 32'hFF) << sh8);
                    x_lat = 4; x_rw = 1;
                end else begin
                    x_wdata = (w & ~(32'hFFFF << sh16)) | ((wd & 32'hFFFF) << sh16);
                    x_lat = 4; x_rw = 1;
                end
                ref_mem[a[5:2]] = x_wdata;
            end else begin
                x_lat = 3; x_rw = 1;
                case (f3)
                    3'd0:    x_rdata = b[7] ? (b | 32'hFFFFFF00) : b;
                    3'd1:    x_rdata = h[15] ? (h | 32'hFFFF0000) : h;
                    3'd2:    x_rdata = w;
                    3'd4:    x_rdata = b;
                    default: x_rdata = h;
                endcase
            end
        end
    endtask

    // Drive one request from a negedge; scramble inputs while busy; end on the negedge after rsp.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] o_rdata, output logic o_err,
                         output int o_lat, output int o_rw, output int o_wr,
                         output logic o_rdy, output logic o_pulse);
        int rw0;
        int wr0;
        rw0 = rw_cnt; wr0 = wr_cnt;
        o_rdy = req_ready; o_rdata = 32'hx; o_err = 1'bx; o_lat = -1;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'($urandom_range(0, 1)); req_store = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7)); req_addr = $urandom(); req_wdata = $urandom();
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                o_lat = c; o_rdata = rsp_rdata; o_err = rsp_err;
                break;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        o_pulse = !rsp_valid && req_ready;
        o_rw = rw_cnt - rw0;
        o_wr = wr_cnt - wr0;
    endtask

    task automatic test_reset();
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_rw, mem_wr} !== 5'b10000 ||
            rsp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_in: ctl=%b rdata=%h addr=%h wdata=%h required ctl=10000 zeros",
                     {req_ready, rsp_valid, rsp_err, mem_rw, mem_wr}, rsp_rdata, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_rw, mem_wr} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_out: ctl=%b required 10000", {req_ready, rsp_valid, rsp_err, mem_rw, mem_wr});
        end
    endtask

    task automatic test_lw();
        set_word(4'd1, 32'h5555_5555);
        ref_model(1'b0, 3'b010, 32'h0010_0004, 32'h0, e_rdata, e_err, e_lat, e_rw, e_wr, e_wdata);
        issue(1'b0, 3'b010, 32'h0010_0004, 32'h0, g_rdata, g_err, g_lat, g_rw, g_wr, g_rdy, g_pulse);
        checks++;
        if (g_rdata !== 32'h5555_5555) begin errors++; $display("FAIL lw_rdata: got %h required 55555555", g_rdata); end
        checks++;
        if (g_lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d required 3", g_lat); end
        checks++;
        if (g_rw !== 1 || g_wr !== 0) begin errors++; $display("FAIL lw_traffic: rw=%0d wr=%0d required 1/0", g_rw, g_wr); end
        checks++;
        if (last_rd_addr !== 32'h0010_0004) begin errors++; $display("FAIL lw_addr: got %h required 00100004", last_rd_addr); end
        checks++;
        if (g_err !== 1'b0 || g_pulse !== 1'b1) begin errors++; $display("FAIL lw_rsp: err=%b pulse=%b required 0/1", g_err, g_pulse); end
    endtask

    task automatic test_lb_lbu();
        set_word(4'd3, 32'h80AA_55CC);
        ref_model(1'b0, 3'b000, 32'h8000_000F, 32'h0, e_rdata, e_err, e_lat, e_rw, e_wr, e_wdata);
        issue(1'b0, 3'b000, 32'h8000_000F, 32'h0, g_rdata, g_err, g_lat, g_rw, g_wr, g_rdy, g_pulse);
        checks++;
        if (g_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext: got %h required ffffff80", g_rdata); end
        ref_model(1'b0, 3'b100, 32'h8000_000F, 32'h0, e_rdata, e_err, e_lat, e_rw, e_wr, e_wdata);
        issue(1'b0, 3'b100, 32'h8000_000F, 32'h0, g_rdata, g_err, g_lat, g_rw, g_wr, g_rdy, g_pulse);
        checks++;
        if (g_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zext: got %h required 00000080", g_rdata); end
    endtask

    task automatic test_sb();
        set_word(4'd3, 32'h1122_3344);
        ref_model(1'b1, 3'b000, 32'h8000_000D, 32'hEE, e_rdata, e_err, e_lat, e_rw, e_wr, e_wdata);
        issue(1'b1, 3'b000, 32'h8000_000D, 32'h0000_00EE, g_rdata, g_err, g_lat, g_rw, g_wr, g_rdy, g_pulse);
        checks++;
        if (last_wr_data !== 32'h1122_EE44) begin errors++; $display("FAIL sb_merge: got %h required 1122ee44", last_wr_data); end
        checks++;
        if (last_wr_addr !== 32'h8000_000C || last_rd_addr !== 32'h8000_000C) begin
            errors++; $display("FAIL sb_addr: wr=%h rd=%h required 8000000c", last_wr_addr, last_rd_addr);
        end
        checks++;
        if (g_rw !== 1 || g_wr !== 1 || g_lat !== 4 || g_err !== 1'b0 || g_rdata !== 32'h0) begin
            errors++; $display("FAIL sb_rsp: rw=%0d wr=%0d lat=%0d err=%b rdata=%h required 1/1/4/0/0",
                               g_rw, g_wr, g_lat, g_err, g_rdata);
        end
    endtask

    task automatic test_misaligned();
        ref_model(1'b1, 3'b001, 32'h8000_0003, 32'h1234, e_rdata, e_err, e_lat, e_rw, e_wr, e_wdata);
        issue(1'b1, 3'b001, 32'h8000_0003, 32'h0000_1234, g_rdata, g_err, g_lat, g_rw, g_wr, g_rdy, g_pulse);
        checks++;
        if (g_err !== 1'b1 || g_lat !== 1 || g_rdata !== 32'h0) begin
            errors++; $display("FAIL sh_misaligned: err=%b lat=%0d rdata=%h required 1/1/0", g_err, g_lat, g_rdata);
        end
        checks++;
        if (g_rw !== 0 || g_wr !== 0) begin errors++; $display("FAIL sh_no_mem: rw=%0d wr=%0d required 0/0", g_rw, g_wr); end
    endtask

    task automatic test_back_to_back();
        ref_model(1'b1, 3'b010, 32'h0010_0008, 32'hDEADBEEF, e_rdata, e_err, e_lat, e_rw, e_wr, e_wdata);
        issue(1'b1, 3'b010, 32'h0010_0008, 32'hDEAD_BEEF, g_rdata, g_err, g_lat, g_rw, g_wr, g_rdy, g_pulse);
        checks++;
        if (g_rw !== 0 || g_wr !== 1 || last_wr_data !== 32'hDEAD_BEEF || g_lat !== 2) begin
            errors++; $display("FAIL sw: rw=%0d wr=%0d data=%h lat=%0d required 0/1/deadbeef/2",
                               g_rw, g_wr, last_wr_data, g_lat);
        end
        ref_model(1'b0, 3'b001, 32'h0010_000A, 32'h0, e_rdata, e_err, e_lat, e_rw, e_wr, e_wdata);
        issue(1'b0, 3'b001, 32'h0010_000A, 32'h0, g_rdata, g_err, g_lat, g_rw, g_wr, g_rdy, g_pulse);
        checks++;
        if (g_rdy !== 1'b1 || g_lat !== 3 || g_rdata !== 32'hFFFF_DEAD) begin
            errors++; $display("FAIL b2b_lh: ready=%b lat=%0d rdata=%h required 1/3/ffffdead", g_rdy, g_lat, g_rdata);
        end
    endtask

    task automatic test_reset_mid_store();
        int wr0;
        wr0 = wr_cnt;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h8000_000D; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_rw, mem_wr} !== 5'b10000 ||
            rsp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid: ctl=%b addr=%h wdata=%h required 10000 zeros",
                               {req_ready, rsp_valid, rsp_err, mem_rw, mem_wr}, mem_addr, mem_wdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt !== wr0) begin errors++; $display("FAIL rst_mid_nowr: writes=%0d required 0", wr_cnt - wr0); end
    endtask

    task automatic test_random();
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom();
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom();
            ref_model(st, f3, a, wd, e_rdata, e_err, e_lat, e_rw, e_wr, e_wdata);
            issue(st, f3, a, wd, g_rdata, g_err, g_lat, g_rw, g_wr, g_rdy, g_pulse);
            checks++;
            if (g_rdata !== e_rdata || g_err !== e_err || g_lat !== e_lat) begin
                errors++; $display("FAIL rnd_rsp[%0d] st=%b f3=%0d a=%h: rdata=%h err=%b lat=%0d required %h/%b/%0d",
                                   n, st, f3, a, g_rdata, g_err, g_lat, e_rdata, e_err, e_lat);
            end
            checks++;
            if (g_rw !== e_rw || g_wr !== e_wr || g_rdy !== 1'b1 || g_pulse !== 1'b1) begin
                errors++; $display("FAIL rnd_traffic[%0d]: rw=%0d wr=%0d rdy=%b pulse=%b required %0d/%0d/1/1",
                                   n, g_rw, g_wr, g_rdy, g_pulse, e_rw, e_wr);
            end
            if (e_wr == 1) begin
                checks++;
                if (last_wr_data !== e_wdata || last_wr_addr !== {a[31:2], 2'b00}) begin
                    errors++; $display("FAIL rnd_store[%0d]: data=%h addr=%h required %h/%h",
                                       n, last_wr_data, last_wr_addr, e_wdata, {a[31:2], 2'b00});
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem_arr[i] !== ref_mem[i]) begin
                errors++; $display("FAIL mem_word[%0d]: got %h required %h", i, mem_arr[i], ref_mem[i]);
            end
        end
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL rw_wr_overlap: cycles=%0d required 0", both_cnt); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) set_word(4'(i), $urandom());
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sb();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_store();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of Memory and drives its rw/wr/Addr/in_bits interface; consumes out_bits.
- Converts RISC-V RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned Memory accesses.
- Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Handshakes with the execute stage through a valid/ready request and a single-cycle response pulse.

Parameters:
- MEM_RD_LAT, 1, cycles from mem_rw assertion to valid mem_rdata (1..4).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  with rsp_valid: misaligned access or illegal funct3
- mem_rw  out  1  Memory read enable
- mem_wr  out  1  Memory write strobe, one cycle
- mem_addr  out  ADDR_W  word-aligned address: req_addr with [1:0] forced to 00
- mem_wdata  out  32  Memory write data
- mem_rdata  in  32  Memory read data

Behaviour:
- Reset: async on rst_n low. All outputs 0 except req_ready, which is 1. FSM goes to IDLE. Latched request and wait counter are cleared. Reset mid-transaction aborts it; no mem_wr is issued after reset asserts.
- Accept: a request is captured on the clk edge where req_valid && req_ready. Address, funct3, store flag and wdata are latched. req_ready drops the next cycle.
- Error check at capture:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]!=0 is misaligned.
  - funct3 011/110/111 is illegal; store funct3 >= 100 is illegal.
  - On error: go to RESP with rsp_err=1 and rsp_rdata=0. No Memory access is made.
- FSM states: IDLE, RD, WAIT, WR, RESP.
  - IDLE -> RD for a load or a sub-word store.
  - IDLE -> WR for SW.
  - IDLE -> RESP on error.
- RD: mem_rw=1 for one cycle, mem_addr valid.
- WAIT: counts MEM_RD_LAT cycles. mem_rdata is sampled on the final count.
  - Load -> RESP.
  - Sub-word store -> WR.
- WR: mem_wr=1 for exactly one cycle, with mem_addr and mem_wdata stable the whole cycle. Then -> RESP.
- Store merge:
  - SB replaces byte lane addr[1:0] of the read word with wdata[7:0].
  - SH replaces lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes wdata unchanged.
- Load extract:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- RESP: rsp_valid=1 for one cycle with rsp_rdata/rsp_err registered. Then -> IDLE, and req_ready returns to 1 in the same cycle as the transition.
- mem_rw and mem_wr are never high together. Both are 0 outside RD and WR.
- Latency with MEM_RD_LAT=1:
  - Load: rsp_valid 3 cycles after accept.
  - SW: 2 cycles after accept.
  - SB/SH: 4 cycles after accept.
- Back-to-back: a new request can be accepted the cycle after rsp_valid. Throughput is not pipelined.
- req_valid deasserting after accept has no effect. Inputs are ignored while busy.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding.
- One natural sub-module: lsu_align, combinational. It provides store merge (old word, wdata, offset, size) and load extract/extend (word, offset, funct3). Reusable by a future cache.

Test Plan:
- Reset mid-store: assert rst_n=0 while in WAIT of an SB → no mem_wr pulse; all outputs return to reset values within the same cycle.
- LW 0x00100004, mem_rdata=0x55555555 → mem_addr=0x00100004, one mem_rw pulse, rsp_rdata=0x55555555, rsp_valid 3 cycles after accept.
- LB 0x8000000F, then LBU at the same address, with word 0x80AA55CC → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SB 0x8000000D, wdata=0x000000EE, old word 0x11223344 → mem_rw then mem_wr, mem_addr=0x8000000C, mem_wdata=0x1122EE44, rsp_err=0.
- SH 0x80000003 → rsp_err=1, rsp_valid 1 cycle after accept, mem_rw and mem_wr never asserted.
- SW 0x00100008 wdata 0xDEADBEEF, followed immediately by LH 0x0010000A → single mem_wr with 0xDEADBEEF and no read. The load is accepted the cycle after rsp_valid and returns rsp_rdata=0xFFFFDEAD.
